// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions.
// State encoding for the multi-cycle multiplier sequencer.
package mips_pkg;

    localparam int WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mult_add_step.sv
// One shift-and-add multiply step: conditional add, then shift {Acc,Q} right.
// The single adder of the multiplier lives here.
module mult_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;

    assign w_addend = i_q[0] ? i_m : '0;
    assign w_sum    = {1'b0, i_acc} + {1'b0, w_addend};

    // Carry-out becomes the new accumulator MSB; sum LSB shifts into Q.
    assign o_acc = w_sum[WIDTH:1];
    assign o_q   = {w_sum[0], i_q[WIDTH-1:1]};

endmodule

// File: rtl/mult_seq_ctrl.sv
// MULT/MULTU sequencer: 32 shift-and-add steps on magnitudes,
// then a sign fix-up into HI/LO. Fixed 33-cycle latency.
module mult_seq_ctrl #(
    parameter int WIDTH = mips_pkg::WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    import mips_pkg::*;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_m;
    logic               r_neg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_can_load;
    logic               w_load;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_res;

    assign w_can_load = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_load     = Start && w_can_load;

    // 0x80000000 maps to itself, which is correct read as unsigned.
    assign w_mag_a = (Signed && OpA[WIDTH-1]) ? -OpA : OpA;
    assign w_mag_b = (Signed && OpB[WIDTH-1]) ? -OpB : OpB;

    mult_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_m   (r_m),
        .o_acc (w_acc_nxt),
        .o_q   (w_q_nxt)
    );

    assign w_prod = {r_acc, r_q};
    assign w_res  = r_neg ? -w_prod : w_prod;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_neg   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (Flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_hi    <= w_res[2*WIDTH-1:WIDTH];
                    r_lo    <= w_res[WIDTH-1:0];
                    r_state <= ST_DONE;
                end
                default: begin
                    if (w_load) begin
                        r_m     <= w_mag_a;
                        r_q     <= w_mag_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_neg   <= Signed && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
                        r_state <= ST_CALC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign Busy = (r_state == ST_CALC) || (r_state == ST_FIX);
    assign Done = (r_state == ST_DONE);
    assign Hi   = r_hi;
    assign Lo   = r_lo;

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Multi-cycle sequencer for MULT/MULTU in the MIPS32 execute stage.
- Computes the 64-bit product into HI/LO over 32 iterations, using a single 32-bit adder with carry-out (shift-and-add).
- Start comes from the ID/EX control path. The pipeline stalls while Busy is high. Hi/Lo feed the HI/LO register file on Done.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  request a multiply; sampled only in IDLE or DONE.
- Signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with Start.
- OpA  in  WIDTH  multiplicand (rs); sampled with Start.
- OpB  in  WIDTH  multiplier (rt); sampled with Start.
- Flush  in  1  synchronous abort from exception or branch flush.
- Busy  out  1  high while the operation is in progress (states CALC and FIX).
- Done  out  1  one-cycle pulse; Hi/Lo are valid.
- Hi  out  WIDTH  product[63:32], held until the next Done.
- Lo  out  WIDTH  product[31:0], held until the next Done.

Behaviour:
- Reset (async, Rst_n=0): state=IDLE; Busy=0, Done=0, Hi=0, Lo=0; counter, accumulator and operand registers cleared.
- States: IDLE, CALC, FIX, DONE. Outputs are decoded from registered state only.
- IDLE: Start=1 at edge E0 -> CALC.
  - Load M = |OpA|, Q = |OpB|. Take the magnitude only when Signed=1; otherwise load raw values.
  - Load Acc(33b)=0, cnt=0, neg = Signed & (OpA[31]^OpB[31]).
  - |0x80000000| = 0x80000000 as an unsigned value; no special case.
- CALC: one step per cycle.
  - sum(33b) = Q[0] ? Acc[31:0]+M : {1'b0,Acc[31:0]}.
  - {Acc,Q} <= {sum,Q} >> 1.
  - cnt++. When cnt=WIDTH-1 at an edge -> FIX. That gives exactly 32 steps, at edges E1..E32.
- FIX (edge E33): Hi/Lo <= neg ? -{Acc[31:0],Q} (64-bit two's complement) : {Acc[31:0],Q}. State -> DONE.
- DONE: Done=1 for exactly one cycle.
  - Start=1 -> CALC (back-to-back allowed); else -> IDLE.
  - Done is visible 33 cycles after the Start edge. Fixed latency, independent of operand values or sign.
- Start in CALC or FIX is ignored. The issuing stage must hold it off while Busy=1.
- Flush=1 in any state -> IDLE at the next edge.
  - Hi/Lo are not updated; Done is not asserted; Busy=0 from that edge.
  - Flush has priority over Start in the same cycle.
- Reset asserted mid-operation: immediate return to reset values, including Hi/Lo=0.
- Only one adder instance is used; no '*' operator anywhere in the design.

Decomposition:
- Shared package mips_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_CALC=2'd1, ST_FIX=2'd2, ST_DONE=2'd3;
  - WIDTH=32.
- One sub-module: mult_add_step. Combinational 32+32 -> 33-bit add with Q[0] select, returning the shifted next {Acc,Q}. This keeps the adder isolated for timing.
- The FIX negation stays inline.

Test Plan:
- Unsigned: Start with Signed=0, OpA=7, OpB=6 -> Busy=1 for 33 cycles; Done pulse at cycle 33; Hi=0x00000000, Lo=0x0000002A.
- Unsigned max: OpA=OpB=0xFFFFFFFF, Signed=0 -> Hi=0xFFFFFFFE, Lo=0x00000001.
- Signed mixed: OpA=0xFFFFFFFD (-3), OpB=5, Signed=1 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
- Signed corner: OpA=OpB=0x80000000, Signed=1 -> Hi=0x40000000, Lo=0x00000000. Back-to-back: Start held in the DONE cycle with 2*3 -> second Done 33 cycles later, Lo=6.
- Flush at cycle 10 of CALC, with previous Hi/Lo=0/42 -> Busy=0 next cycle; no Done; Hi/Lo stay 0/42. Start pulsed during CALC is ignored, and the result is unchanged.
- Rst_n pulsed low mid-CALC (async, between edges) -> Busy=0, Done=0, Hi=Lo=0 immediately. A fresh Start after release completes normally.
